// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side adapters: packed-word layout,
// field offsets and the lane packing helper.
package fifo_pkg;

    localparam int PK_IW    = 8;
    localparam int PK_RATIO = 4;
    localparam int PK_CW    = $clog2(PK_RATIO);
    localparam int PK_LW    = PK_IW * PK_RATIO;
    localparam int PK_OW    = PK_LW + PK_CW + 1;

    // Bit positions inside a packed word: last on top, count below it, lanes in the LSBs.
    localparam int LAST_POS = PK_OW - 1;
    localparam int CNT_POS  = PK_LW;

    typedef struct packed {
        logic                last;
        logic [PK_CW-1:0]    cnt;
        logic [PK_LW-1:0]    lanes;
    } packed_word_t;

    // Forms the word for a beat completing at lane idx; lanes above idx are
    // expected to be zero already in acc.
    function automatic packed_word_t pack_word(
        input logic [PK_LW-1:0] acc,
        input logic [PK_IW-1:0] beat,
        input logic [PK_CW-1:0] idx,
        input logic             last
    );
        packed_word_t w;
        w       = '0;
        w.lanes = acc;
        w.lanes[int'(idx)*PK_IW +: PK_IW] = beat;
        w.cnt   = idx;
        w.last  = last;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_packer_out_reg.sv
// Output holding register in front of a FIFO write port: holds one word until
// the FIFO is not full, and can be reloaded in the same cycle it is written.
module pack_out_reg #(
    parameter int W = 8
) (
    input  logic         w_clk,
    input  logic         w_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         fifo_full,
    output logic         can_load,
    output logic         fifo_w_en,
    output logic [W-1:0] fifo_w_data
);

    logic out_valid;
    logic fifo_wr;

    // Handshake: a word leaves when out_valid && !fifo_full; a new word may be
    // loaded whenever the register is empty or is being emptied this cycle.
    assign fifo_wr   = out_valid && !fifo_full;
    assign can_load  = !out_valid || fifo_wr;
    assign fifo_w_en = fifo_wr;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            out_valid   <= 1'b0;
            fifo_w_data <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            fifo_w_data <= load_data;
        end else if (fifo_wr) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one FIFO word with last/count sideband and
// writes it through a holding register; widths follow fifo_pkg.
module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int IW    = PK_IW,
    parameter int RATIO = PK_RATIO,
    parameter int CW    = $clog2(RATIO),
    parameter int OW    = IW * RATIO + CW + 1
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    input  logic          fifo_full,
    output logic          fifo_w_en,
    output logic [OW-1:0] fifo_w_data,
    output logic [15:0]   words_written
);

    localparam int LW = IW * RATIO;

    logic [LW-1:0] acc;
    logic [CW-1:0] idx;
    logic          acc_done;
    logic          acc_last;
    logic          run_q;

    logic          accept;
    logic          complete_now;
    logic          can_load;
    logic          move;
    packed_word_t  move_word;

    // Input handshake: a beat transfers on in_valid && in_ready; the source
    // holds the beat stable while in_ready is low.
    assign in_ready     = run_q && !acc_done;
    assign accept       = in_valid && in_ready;
    assign complete_now = accept && (in_last || idx == CW'(RATIO - 1));
    assign move         = (complete_now || acc_done) && can_load;

    // A parked word already holds its final beat in acc; otherwise merge the live beat.
    always_comb begin
        move_word = pack_word(acc, in_data, idx, in_last);
        if (acc_done) begin
            move_word.lanes = acc;
            move_word.cnt   = idx;
            move_word.last  = acc_last;
        end
    end

    // run_q keeps in_ready low during reset and for the release cycle.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            acc      <= '0;
            idx      <= '0;
            acc_done <= 1'b0;
            acc_last <= 1'b0;
        end else if (move) begin
            acc      <= '0;
            idx      <= '0;
            acc_done <= 1'b0;
            acc_last <= 1'b0;
        end else if (complete_now) begin
            // Park the finished word in acc; idx stays at the completion lane.
            acc[idx*IW +: IW] <= in_data;
            acc_last          <= in_last;
            acc_done          <= 1'b1;
        end else if (accept) begin
            acc[idx*IW +: IW] <= in_data;
            idx               <= idx + 1'b1;
        end
    end

    pack_out_reg #(
        .W (OW)
    ) u_out_reg (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .load        (move),
        .load_data   (move_word),
        .fifo_full   (fifo_full),
        .can_load    (can_load),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            words_written <= 16'd0;
        end else if (fifo_w_en) begin
            words_written <= words_written + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_fifo_wr_packer;
    import fifo_pkg::*;

    localparam int IW    = PK_IW;
    localparam int RATIO = PK_RATIO;
    localparam int CW    = PK_CW;
    localparam int LW    = PK_LW;
    localparam int OW    = PK_OW;

    logic          w_clk;
    logic          w_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          fifo_full;
    logic          fifo_w_en;
    logic [OW-1:0] fifo_w_data;
    logic [15:0]   words_written;

    int checks;
    int errors;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    bit            mon_en;
    bit            full_wr_seen;

    logic [LW-1:0] m_lanes;
    int            m_n;

    fifo_wr_packer dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .fifo_full     (fifo_full),
        .fifo_w_en     (fifo_w_en),
        .fifo_w_data   (fifo_w_data),
        .words_written (words_written)
    );

    // ---------------- clock / reset ----------------
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic model_clear();
        m_lanes = '0;
        m_n     = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        w_rst_n  = 1'b0;
        step();
        step();
        w_rst_n = 1'b1;
        model_clear();
        step();
    endtask

    // ---------------- reference model ----------------
    // A frame is cut into words of at most RATIO beats; the last beat of a
    // frame closes the current word early. count field = beats in word - 1.
    task automatic model_beat(input logic [IW-1:0] d, input logic l);
        logic [OW-1:0] w;
        m_lanes[m_n*IW +: IW] = d;
        m_n++;
        if (m_n == RATIO || l) begin
            w = '0;
            w[LW-1:0]          = m_lanes;
            w[CNT_POS +: CW]   = CW'(m_n - 1);
            w[LAST_POS]        = l;
            exp_q.push_back(w);
            m_lanes = '0;
            m_n     = 0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge w_clk) begin
        if (mon_en && w_rst_n && fifo_w_en) begin
            got_q.push_back(fifo_w_data);
            if (fifo_full) full_wr_seen = 1'b1;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [IW-1:0] d, input logic l, input int max_wait,
                             output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && stalls < max_wait) begin
            step();
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept data=%h waited=%0d cycles, required accept within %0d",
                     d, stalls, max_wait);
        end else begin
            model_beat(d, l);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_writes(input int n, output bit ok);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            step();
            t++;
        end
        step();
        ok = (got_q.size() >= n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (fifo_w_en !== 1'b0) begin
            errors++; $display("FAIL reset_w_en got=%b exp=0", fifo_w_en);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (words_written !== 16'd0) begin
            errors++; $display("FAIL reset_words got=%0d exp=0", words_written);
        end
        checks++;
        if (fifo_w_data !== '0) begin
            errors++; $display("FAIL reset_w_data got=%h exp=0", fifo_w_data);
        end
        w_rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_streaming();
        logic [OW-1:0] exp_s[2];
        int st;
        int stall_sum;
        bit ok;
        exp_s[0] = {1'b0, 2'd3, 32'h44332211};
        exp_s[1] = {1'b1, 2'd3, 32'h88776655};
        stall_sum = 0;
        for (int i = 1; i <= 8; i++) begin
            send_beat(IW'(i * 8'h11), (i == 8), 20, st);
            stall_sum += st;
        end
        // Cycle after the completing beat: the word must already be on the port.
        checks++;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== exp_s[1]) begin
            errors++;
            $display("FAIL stream_latency w_en=%b data=%h exp w_en=1 data=%h",
                     fifo_w_en, fifo_w_data, exp_s[1]);
        end
        checks++;
        if (stall_sum != 0) begin
            errors++; $display("FAIL stream_ready stalls=%0d exp=0", stall_sum);
        end
        wait_writes(2, ok);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL stream_count got=%0d exp=2", got_q.size());
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_s[i]) begin
                errors++; $display("FAIL stream_word%0d got=%h exp=%h", i, got_q[i], exp_s[i]);
            end
        end
        checks++;
        if (words_written !== 16'd2) begin
            errors++; $display("FAIL stream_words_written got=%0d exp=2", words_written);
        end
        model_clear();
    endtask

    task automatic test_partial_flush();
        logic [OW-1:0] exp_w;
        int st;
        bit ok;
        exp_w = {1'b1, 2'd2, 32'h00A3A2A1};
        send_beat(8'hA1, 1'b0, 20, st);
        send_beat(8'hA2, 1'b0, 20, st);
        send_beat(8'hA3, 1'b1, 20, st);
        wait_writes(1, ok);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL partial_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_w) begin
                errors++; $display("FAIL partial_word got=%h exp=%h", got_q[0], exp_w);
            end
        end
        model_clear();
    endtask

    task automatic test_single_beat();
        logic [OW-1:0] exp_s[2];
        int st;
        bit ok;
        exp_s[0] = {1'b1, 2'd0, 32'h0000005A};
        exp_s[1] = {1'b1, 2'd3, 32'hB4B3B2B1};
        send_beat(8'h5A, 1'b1, 20, st);
        checks++;
        if (fifo_w_en !== 1'b1 || fifo_w_data !== exp_s[0]) begin
            errors++;
            $display("FAIL single_latency w_en=%b data=%h exp w_en=1 data=%h",
                     fifo_w_en, fifo_w_data, exp_s[0]);
        end
        for (int i = 1; i <= 4; i++) send_beat(IW'(8'hB0 + i), (i == 4), 20, st);
        wait_writes(2, ok);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL single_count got=%0d exp=2", got_q.size());
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_s[i]) begin
                errors++; $display("FAIL single_word%0d got=%h exp=%h", i, got_q[i], exp_s[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_full_backpressure();
        logic [OW-1:0] exp_s[3];
        int st;
        bit ok;
        exp_s[0] = {1'b0, 2'd3, 32'h04030201};
        exp_s[1] = {1'b0, 2'd3, 32'h08070605};
        exp_s[2] = {1'b1, 2'd3, 32'h0C0B0A09};
        full_wr_seen = 1'b0;
        fifo_full    = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(IW'(i), 1'b0, 20, st);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready_drop got=%b exp=0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'h09;
        in_last  = 1'b0;
        repeat (5) step();
        checks++;
        if (in_ready !== 1'b0 || fifo_w_en !== 1'b0) begin
            errors++;
            $display("FAIL full_hold in_ready=%b w_en=%b exp both 0", in_ready, fifo_w_en);
        end
        checks++;
        if (got_q.size() != 0 || full_wr_seen) begin
            errors++;
            $display("FAIL full_no_write writes=%0d exp=0", got_q.size());
        end
        fifo_full = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_release_ready got=%b exp=1", in_ready);
        end
        for (int i = 9; i <= 12; i++) send_beat(IW'(i), (i == 12), 20, st);
        wait_writes(3, ok);
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL full_count got=%0d exp=3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_s[i]) begin
                errors++; $display("FAIL full_word%0d got=%h exp=%h", i, got_q[i], exp_s[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_mid_frame_reset();
        logic [OW-1:0] exp_w;
        int st;
        bit ok;
        exp_w = {1'b0, 2'd3, 32'h04030201};
        send_beat(8'hE1, 1'b0, 20, st);
        send_beat(8'hE2, 1'b0, 20, st);
        w_rst_n = 1'b0;
        step();
        w_rst_n = 1'b1;
        model_clear();
        for (int i = 1; i <= 4; i++) send_beat(IW'(i), 1'b0, 20, st);
        wait_writes(1, ok);
        repeat (3) step();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midreset_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_w) begin
                errors++; $display("FAIL midreset_word got=%h exp=%h", got_q[0], exp_w);
            end
        end
        checks++;
        if (words_written !== 16'd1) begin
            errors++; $display("FAIL midreset_words_written got=%0d exp=1", words_written);
        end
        model_clear();
    endtask

    task automatic test_random();
        bit done;
        bit ok;
        int n_exp;
        logic [OW-1:0] e;
        logic [OW-1:0] g;
        done         = 1'b0;
        full_wr_seen = 1'b0;
        fork
            begin
                int st;
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send_beat(IW'($urandom), (i == 199) || ($urandom_range(0, 4) == 0), 200, st);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge w_clk);
                    #1;
                    fifo_full = ($urandom_range(0, 2) == 0);
                end
            end
        join
        fifo_full = 1'b0;
        n_exp = exp_q.size();
        wait_writes(n_exp, ok);
        checks++;
        if (got_q.size() != n_exp) begin
            errors++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), n_exp);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL random_word got=%h exp=%h", g, e);
            end
        end
        checks++;
        if (full_wr_seen) begin
            errors++; $display("FAIL random_write_while_full seen=1 exp=0");
        end
        model_clear();
    endtask

    task automatic test_wrap();
        mon_en = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = IW'($urandom);
        repeat (65536) step();
        checks++;
        if (words_written !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_before got=%h exp=ffff", words_written);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        checks++;
        if (words_written !== 16'h0000) begin
            errors++; $display("FAIL wrap_after got=%h exp=0000", words_written);
        end
        step();
        checks++;
        if (fifo_w_en !== 1'b0 || words_written !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_idle w_en=%b words=%h exp w_en=0 words=0000",
                     fifo_w_en, words_written);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks       = 0;
        errors       = 0;
        w_rst_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        fifo_full    = 1'b0;
        mon_en       = 1'b1;
        full_wr_seen = 1'b0;
        m_lanes      = '0;
        m_n          = 0;
        test_reset();
        test_streaming();
        test_partial_flush();
        test_single_beat();
        test_full_backpressure();
        test_mid_frame_reset();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
- Write-domain upstream stage of the async FIFO. Accepts a narrow valid/ready byte stream with end-of-frame marking.
- Packs RATIO input beats into one wide FIFO word carrying sideband metadata: a last flag and a valid-lane count.
- Drives the FIFO write port (w_en/w_data) and obeys its registered full flag.
- Double-registered (accumulator + output holding register), so input keeps flowing while one packed word waits on a full FIFO.

Parameters:
- IW, 8, input beat width in bits.
- RATIO, 4, input beats per packed word; power of two, at least 2.
- CW, $clog2(RATIO), width of the count field (number of valid lanes minus 1).
- OW, IW*RATIO+CW+1, packed word width; the FIFO DW is set equal to OW.

Ports:
- w_clk  in  1  write-domain clock.
- w_rst_n  in  1  asynchronous active-low reset, w_clk domain.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  IW  input beat.
- in_last  in  1  final beat of frame; forces a flush of the partial word.
- fifo_full  in  1  FIFO full flag (registered in FIFO, w_clk domain).
- fifo_w_en  out  1  FIFO write strobe.
- fifo_w_data  out  OW  packed word: [OW-1] last, [OW-2 -: CW] count-1, [IW*RATIO-1:0] lanes; lane 0 = first beat, in LSBs.
- words_written  out  16  wrapping count of FIFO writes.

Behaviour:
- Reset (async, w_rst_n low): acc, lane index, acc_done and out_valid cleared; in_ready=0 while in reset; fifo_w_en=0; fifo_w_data=0; words_written=0. Partial words are discarded. Reset mid-frame loses that frame; there is no recovery flag.
- Beat accept: in_ready = !acc_done. On accept, in_data is written into lane[idx] of acc and idx increments.
- Word complete: on the accepted beat where idx==RATIO-1, or on any accepted beat with in_last=1. The packed word is formed from acc plus the current beat. count = idx at completion; last = in_last. Unused lanes are zero.
- fifo_wr = out_valid && !fifo_full. fifo_w_en = fifo_wr (combinational from registers only). fifo_w_data = out register.
- Move acc→out when a word completes (this cycle, or pending via acc_done) and (!out_valid || fifo_wr).
  - On a move: out_valid=1, idx=0, acc cleared, acc_done=0.
  - If the word completes but no move is possible: acc_done=1 and in_ready drops next cycle.
- out_valid clears on fifo_wr unless a move reloads it in the same cycle.
- Latency: a completing beat accepted in cycle N gives fifo_w_en=1 in cycle N+1, provided out was free and fifo_full=0.
- Throughput: one FIFO word per cycle while not full; in_ready stays 1 continuously when fifo_full=0.
- Full handling:
  - fifo_full=1 holds out; the packer absorbs up to RATIO further beats into acc.
  - A second completed word sets acc_done and backpressures the input.
  - When fifo_full deasserts: write in that cycle, move acc→out in the same cycle, in_ready=1 the next cycle.
- Simultaneous events:
  - Completion + fifo_wr in the same cycle → direct move, no bubble.
  - in_last on lane 0 → single-lane word, count=0.
  - in_valid with in_ready=0 → beat held by the source (AXI-style; in_data must be stable).
- words_written increments on fifo_wr and wraps 0xFFFF→0.
- Never write while fifo_full=1; fifo_w_data is stable while out_valid && fifo_full.

Decomposition:
- Shared package fifo_pkg:
  - Packed-word struct typedef (last, cnt, lanes) parameterised via localparams.
  - Field-offset constants.
  - Function pack_word(acc, beat, idx, last).
- One natural sub-module: pack_out_reg, the output holding register with the valid/full handshake. Reusable for other FIFO write-side adapters.
- Everything else stays flat in fifo_wr_packer.

Test Plan:
- Reset: hold w_rst_n=0 → fifo_w_en=0, in_ready=0, words_written=0. Release → in_ready=1 next cycle.
- Streaming: 8 beats 0x11..0x88, in_last on beat 8, fifo_full=0 → two writes.
  - Write 1: lanes 0x44332211, cnt=3, last=0.
  - Write 2: 0x88776655, cnt=3, last=1, one cycle after beat 8.
  - words_written=2.
- Partial flush: 3 beats 0xA1,0xA2,0xA3 with in_last on the 3rd → one write, lanes 0x00A3A2A1, cnt=2, last=1.
- Full backpressure:
  - fifo_full=1 from cycle 0, stream 12 beats → in_ready drops after beat 8; fifo_w_en never asserted.
  - Release fifo_full → words written in order with no loss or duplication; in_ready returns 1 the cycle after.
- Single-beat frame: beat 0x5A with in_last=1 → lanes 0x0000005A, cnt=0, last=1; the next frame starts at lane 0.
- Mid-frame reset: 2 beats, assert w_rst_n for 1 cycle, then 4 beats 0x01..0x04 → single write 0x04030201 with cnt=3; no stale data.
